instr_fetch_queue: RTL and testbench

- Instruction prefetch queue placed between the fetch stage (PC + instruction memory) and the IF/ID pipe register.
- Buffers {PCPlus1, instruction} pairs so that fetch keeps running while decode is held by a hazard stall.
- Discards all buffered entries on a branch/jump redirect (flush), so mispredicted-path instructions never reach decode.
- Its occupancy flags throttle fetch, which has a 1-cycle synchronous instruction-memory latency.

---
 rtl/instr_fetch_queue.sv | 86 ++++++++
 tb/tb_instr_fetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Prefetch queue between instruction fetch and the IF/ID register: holds {PCPlus1, instr}
// pairs while decode stalls, and drops everything on a redirect.
module instr_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [PC_W-1:0]            push_pc_plus1,
    input  logic [INSTR_W-1:0]         push_instr,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [PC_W-1:0]            pop_pc_plus1,
    output logic [INSTR_W-1:0]         pop_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_push_fire;
    logic               w_pop_fire;
    logic               w_empty;

    // Handshake decode; full blocks push even when a pop frees a slot this cycle.
    always_comb begin
        w_empty     = (r_count == {CW{1'b0}});
        push_ready  = enable && (r_count < CW'(DEPTH));
        pop_valid   = enable && !w_empty;
        w_push_fire = push_valid && push_ready;
        w_pop_fire  = pop_valid && pop_ready;
        empty       = w_empty;
        almost_full = (r_count >= CW'(DEPTH - 1));
        count       = r_count;
        if (w_empty) begin
            pop_pc_plus1 = {PC_W{1'b0}};
            pop_instr    = {INSTR_W{1'b0}};
        end else begin
            pop_pc_plus1 = r_mem_pc[r_rd_ptr];
            pop_instr    = r_mem_instr[r_rd_ptr];
        end
    end

    // Pointer, occupancy and storage update; flush discards same-cycle transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (enable) begin
            if (flush) begin
                r_wr_ptr <= {AW{1'b0}};
                r_rd_ptr <= {AW{1'b0}};
                r_count  <= {CW{1'b0}};
            end else begin
                if (w_push_fire) begin
                    r_mem_pc[r_wr_ptr]    <= push_pc_plus1;
                    r_mem_instr[r_wr_ptr] <= push_instr;
                    r_wr_ptr              <= r_wr_ptr + AW'(1);
                end
                if (w_pop_fire) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push_fire, w_pop_fire})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, PC_W=8, INSTR_W=32).
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, enable, flush;
    logic        push_valid, push_ready;
    logic [7:0]  push_pc_plus1;
    logic [31:0] push_instr;
    logic        pop_valid, pop_ready;
    logic [7:0]  pop_pc_plus1;
    logic [31:0] pop_instr;
    logic [2:0]  count;
    logic        almost_full, empty;

    int tests = 0;
    int fails = 0;

    instr_fetch_queue #(.DEPTH(4), .PC_W(8), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc_plus1(push_pc_plus1), .push_instr(push_instr),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_pc_plus1(pop_pc_plus1), .pop_instr(pop_instr),
        .count(count), .almost_full(almost_full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (count > 3'd4) begin
            $display("FAIL count_bound: got %0d, must be <= 4", count);
            fails++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; enable = 1'b1; flush = 1'b0;
        push_valid = 1'b0; pop_ready = 1'b0;
        push_pc_plus1 = 8'h00; push_instr = 32'h0;
    endtask

    task automatic test_reset_and_fill();
        logic [31:0] instrs [4];
        instrs[0] = 32'h20010005; instrs[1] = 32'h20020007;
        instrs[2] = 32'h00221820; instrs[3] = 32'hAC030000;
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        tests++;
        if (count !== 3'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || almost_full !== 1'b0 ||
            pop_instr !== 32'h0 || pop_pc_plus1 !== 8'h00 || push_ready !== 1'b1) begin
            $display("FAIL reset_state: count=%0d empty=%b pop_valid=%b af=%b instr=%h pc=%h push_ready=%b, want 0 1 0 0 0 0 1",
                     count, empty, pop_valid, almost_full, pop_instr, pop_pc_plus1, push_ready);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_pc_plus1 = 8'(i + 1);
            push_instr = instrs[i];
            step();
            tests++;
            if (count !== 3'(i + 1) || almost_full !== (i + 1 >= 3)) begin
                $display("FAIL fill_count[%0d]: count=%0d af=%b, want %0d %b", i, count, almost_full, i + 1, (i + 1 >= 3));
                fails++;
            end
        end
        tests++;
        if (push_ready !== 1'b0) begin
            $display("FAIL full_push_ready: got %b want 0", push_ready);
            fails++;
        end
        push_pc_plus1 = 8'h55; push_instr = 32'hDEADBEEF;
        step();
        push_valid = 1'b0;
        tests++;
        if (count !== 3'd4 || pop_instr !== 32'h20010005 || pop_pc_plus1 !== 8'h01) begin
            $display("FAIL fifth_push_ignored: count=%0d head=%h pc=%h, want 4 20010005 01", count, pop_instr, pop_pc_plus1);
            fails++;
        end
    endtask

    task automatic test_drain_order();
        logic [31:0] instrs [4];
        instrs[0] = 32'h20010005; instrs[1] = 32'h20020007;
        instrs[2] = 32'h00221820; instrs[3] = 32'hAC030000;
        pop_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                tests++;
                if (pop_valid !== 1'b1 || pop_instr !== instrs[i] || pop_pc_plus1 !== 8'(i + 1)) begin
                    $display("FAIL drain_order[%0d]: valid=%b instr=%h pc=%h, want 1 %h %h",
                             i, pop_valid, pop_instr, pop_pc_plus1, instrs[i], 8'(i + 1));
                    fails++;
                end
            end
            step();
            tests++;
            if (count !== 3'(i < 4 ? 3 - i : 0)) begin
                $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, (i < 4 ? 3 - i : 0));
                fails++;
            end
        end
        tests++;
        if (empty !== 1'b1 || pop_instr !== 32'h0 || pop_valid !== 1'b0 || almost_full !== 1'b0) begin
            $display("FAIL drain_empty: empty=%b instr=%h valid=%b af=%b, want 1 0 0 0", empty, pop_instr, pop_valid, almost_full);
            fails++;
        end
        pop_ready = 1'b0;
    endtask

    task automatic test_wraparound();
        push_valid = 1'b1; pop_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_pc_plus1 = 8'(k); push_instr = 32'h10000000 + 32'(k);
            step();
        end
        pop_ready = 1'b1;
        for (int k = 2; k < 12; k++) begin
            push_pc_plus1 = 8'(k); push_instr = 32'h10000000 + 32'(k);
            tests++;
            if (pop_instr !== 32'h10000000 + 32'(k - 2) || pop_pc_plus1 !== 8'(k - 2)) begin
                $display("FAIL stream_data[%0d]: instr=%h pc=%h, want %h %h",
                         k, pop_instr, pop_pc_plus1, 32'h10000000 + 32'(k - 2), 8'(k - 2));
                fails++;
            end
            step();
            tests++;
            if (count !== 3'd2) begin
                $display("FAIL stream_count[%0d]: got %0d want 2", k, count);
                fails++;
            end
        end
        push_valid = 1'b0; pop_ready = 1'b0;
        tests++;
        if (pop_instr !== 32'h1000000A) begin
            $display("FAIL stream_head_after: got %h want 1000000a", pop_instr);
            fails++;
        end
    endtask

    task automatic test_flush();
        push_valid = 1'b1; push_pc_plus1 = 8'h0C; push_instr = 32'h1000000C;
        step();
        tests++;
        if (count !== 3'd3) begin
            $display("FAIL flush_setup: count=%0d want 3", count);
            fails++;
        end
        flush = 1'b1; push_valid = 1'b1; pop_ready = 1'b1;
        push_pc_plus1 = 8'h10; push_instr = 32'h08000010;
        step();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        tests++;
        if (count !== 3'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || pop_instr !== 32'h0) begin
            $display("FAIL flush_clear: count=%0d empty=%b valid=%b instr=%h, want 0 1 0 0", count, empty, pop_valid, pop_instr);
            fails++;
        end
        push_valid = 1'b1; push_pc_plus1 = 8'h21; push_instr = 32'h0000AAAA;
        step();
        push_valid = 1'b0;
        tests++;
        if (count !== 3'd1 || pop_instr !== 32'h0000AAAA || pop_pc_plus1 !== 8'h21) begin
            $display("FAIL flush_no_stale: count=%0d head=%h pc=%h, want 1 0000aaaa 21", count, pop_instr, pop_pc_plus1);
            fails++;
        end
    endtask

    task automatic test_enable_freeze();
        push_valid = 1'b1; push_pc_plus1 = 8'h22; push_instr = 32'h0000BBBB;
        step();
        enable = 1'b0; flush = 1'b1; push_valid = 1'b1; pop_ready = 1'b1;
        push_pc_plus1 = 8'h77; push_instr = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (push_ready !== 1'b0 || pop_valid !== 1'b0 || pop_instr !== 32'h0000AAAA) begin
                $display("FAIL freeze_outputs[%0d]: push_ready=%b pop_valid=%b head=%h, want 0 0 0000aaaa",
                         i, push_ready, pop_valid, pop_instr);
                fails++;
            end
            step();
            tests++;
            if (count !== 3'd2) begin
                $display("FAIL freeze_count[%0d]: got %0d want 2", i, count);
                fails++;
            end
        end
        enable = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b1;
        #1;
        tests++;
        if (pop_valid !== 1'b1 || pop_instr !== 32'h0000AAAA || pop_pc_plus1 !== 8'h21) begin
            $display("FAIL unfreeze_head: valid=%b head=%h pc=%h, want 1 0000aaaa 21", pop_valid, pop_instr, pop_pc_plus1);
            fails++;
        end
        step();
        tests++;
        if (count !== 3'd1 || pop_instr !== 32'h0000BBBB) begin
            $display("FAIL unfreeze_pop: count=%0d head=%h, want 1 0000bbbb", count, pop_instr);
            fails++;
        end
        step();
        pop_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_pc_plus1 = 8'(8'h30 + i); push_instr = 32'hC0DE0000 + 32'(i);
            step();
        end
        tests++;
        if (count !== 3'd4 || almost_full !== 1'b1) begin
            $display("FAIL refill: count=%0d af=%b, want 4 1", count, almost_full);
            fails++;
        end
        rst = 1'b1; pop_ready = 1'b1;
        step();
        rst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        tests++;
        if (count !== 3'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || almost_full !== 1'b0 ||
            pop_instr !== 32'h0 || pop_pc_plus1 !== 8'h00) begin
            $display("FAIL reset_mid_op: count=%0d empty=%b valid=%b af=%b instr=%h pc=%h, want 0 1 0 0 0 0",
                     count, empty, pop_valid, almost_full, pop_instr, pop_pc_plus1);
            fails++;
        end
    endtask

    initial begin
        idle();
        test_reset_and_fill();
        test_drain_order();
        test_wraparound();
        test_flush();
        test_enable_freeze();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
